mult_arbiter_ctrl: RTL and testbench
====================================

# mult_arbiter_ctrl

Round-robin scheduler that shares the single repeated-addition multiplier datapath (A register, B down-counter, P accumulator) among NREQ requesters. It grants one requester at a time and steers its operands into the datapath through `sel`. It sequences the datapath loads, clear, accumulate and decrement strobes until the B-zero flag `eqz` is seen, then returns a one-cycle `done` to that requester. It sits between the requesting client blocks and the datapath, replacing a single-user start/eqz control FSM.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `SELW`, 2: width of `sel`, must be ≥ clog2(NREQ)
- `CNTW`, 8: width of the iteration counter
- `MAX_ITER`, 255: accumulate-iteration limit before abort (≤ 2^CNTW−1)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  level request per requester; held until its `done`
- `eqz`  in  1  datapath B counter == 0
- `ld_a`  out  1  load A register from selected operand
- `ld_b`  out  1  load B counter from selected operand
- `clr`  out  1  clear P accumulator
- `ld_p`  out  1  P <= P + A
- `dec`  out  1  B <= B − 1
- `sel`  out  SELW  index of granted requester (operand/result mux select)
- `gnt`  out  NREQ  one-hot grant
- `done`  out  NREQ  one-hot, one-cycle completion pulse
- `err`  out  1  one-cycle pulse with `done` when the op aborted on MAX_ITER
- `busy`  out  1  high in every state except IDLE
- `iter_cnt`  out  CNTW  accumulate iterations of current/last op

## Operation
- States: IDLE, GRANT, LOADB, CHECK, ACC, DONE.
- IDLE: if any `req` bit is set, pick the winner round-robin. Search starts at `ptr+1` mod NREQ. The winner's index is registered into `sel` and `gnt`, `ptr` <= winner, and the FSM goes to GRANT. Otherwise it stays in IDLE.
- GRANT: `ld_a`=1; `iter_cnt` <= 0; go to LOADB.
- LOADB: `ld_b`=1, `clr`=1; go to CHECK.
- CHECK: all strobes 0.
  - If `eqz`, go to DONE.
  - Else if `iter_cnt` == MAX_ITER, go to DONE with the abort flag set.
  - Else go to ACC.
- ACC: `ld_p`=1, `dec`=1, `iter_cnt`++; go to CHECK.
- DONE: `done[sel]`=1; `err`=abort flag; go to IDLE. `gnt` and `sel` clear on exit.
- Output decoding:
  - Strobes, `done`, `err` and `busy` are Moore outputs decoded from the state register.
  - `gnt` and `sel` are registered; `gnt` is held from GRANT through DONE inclusive.
  - At most one strobe pair is active per cycle.
- Arbitration happens only in IDLE. A requester's `req` is ignored while another op is in progress.
- If `req` of the granted requester drops mid-op, the op still completes and `done` still pulses.
- `iter_cnt` holds its final value after DONE until the next GRANT. It never exceeds MAX_ITER, so it cannot wrap.
- `eqz` is only sampled in CHECK. Its value in any other state is ignored.
- Reset, including mid-operation:
  - State → IDLE; `gnt`, `sel`, `iter_cnt` and the abort flag → 0.
  - `ptr` → NREQ−1, so requester 0 has top priority after reset.
  - All outputs are 0 in the cycle after `rst` is sampled high. No `done` is issued for an aborted op.

## Timing
- Count GRANT as cycle 1. Then LOADB is cycle 2 and the first CHECK is cycle 3.
- For B=n: `done` in cycle 2n+4; n=0 → cycle 4.
- Grant latency: `req` high before edge k (FSM in IDLE) → GRANT and `gnt` valid in cycle after edge k.
- Back-to-back: at least one IDLE cycle between DONE and the next GRANT. The just-served requester has lowest priority in that arbitration.
- Abort: eqz never asserted → `done`+`err` in cycle 2·MAX_ITER+4.
- Datapath contract: `eqz` reflects the B register updated at the previous edge, so `eqz` is valid in CHECK.

## Test plan
- Single op: `req`=0001, datapath A=5, B=3 → `gnt`=0001 in cycle 1; `ld_a` in cycle 1; `ld_b`+`clr` in cycle 2; `ld_p`+`dec` in cycles 4, 6, 8; `done`=0001 in cycle 10; P=15; `iter_cnt`=3; `err`=0.
- Zero operand: B=0 → no `ld_p`/`dec` pulses; `done` in cycle 4; P=0; `iter_cnt`=0.
- Round-robin: `req`=1111 held continuously after reset → grants in order 0,1,2,3,0. Each next GRANT follows exactly one IDLE cycle after the prior DONE.
- Abort: MAX_ITER=4, `eqz` tied 0 → four ACC cycles, then `done`+`err` in cycle 12; `iter_cnt`=4; the next request is served normally.
- Reset mid-op: `rst` for 1 cycle during the 2nd ACC of a B=5 op → next cycle all outputs 0 and no `done` pulse. A new `req`=0100 is then granted as index 2, and the arbitration pointer restarts at 0.
- Requester drop: `req[1]` deasserted in cycle 3 of a B=2 op → op completes, `done`=0010 in cycle 8.

Source files
------------

// File: rtl/mult_arbiter_ctrl.sv
// mult_arbiter_ctrl
//
// Round-robin scheduler that shares one repeated-addition multiplier datapath
// (A register, B down-counter, P accumulator) among NREQ requesters. One
// requester is granted at a time. Its operands are steered into the datapath
// through `sel`. The block then sequences load / clear / accumulate / decrement
// strobes until the datapath reports B == 0 (`eqz`), and finally pulses `done`
// for that requester.
//
// Handshake: `req[i]` is a level request. The requester holds it until it sees
// its one-cycle `done[i]`. Arbitration only happens in IDLE. Once granted, an
// operation always runs to completion, even if the requester drops `req`. Only
// reset cancels an operation, and a cancelled operation issues no `done`.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   req       in   [NREQ]  level request per requester
//   eqz       in   datapath B == 0; sampled only in CHECK
//   ld_a      out  load A from the selected operand
//   ld_b      out  load B from the selected operand
//   clr       out  clear P
//   ld_p      out  P <= P + A
//   dec       out  B <= B - 1
//   sel       out  [SELW]  index of the granted requester
//   gnt       out  [NREQ]  one-hot grant, held from GRANT through DONE
//   done      out  [NREQ]  one-hot, one-cycle completion pulse
//   err       out  pulses with `done` when the op hit MAX_ITER
//   busy      out  high in every state except IDLE
//   iter_cnt  out  [CNTW]  accumulate iterations of the current/last op
module mult_arbiter_ctrl #(
    parameter int NREQ     = 4,
    parameter int SELW     = 2,
    parameter int CNTW     = 8,
    parameter int MAX_ITER = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            eqz,
    output logic            ld_a,
    output logic            ld_b,
    output logic            clr,
    output logic            ld_p,
    output logic            dec,
    output logic [SELW-1:0] sel,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            err,
    output logic            busy,
    output logic [CNTW-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_LOADB = 3'd2,
        S_CHECK = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [SELW-1:0] PTR_RST  = SELW'(NREQ - 1);
    localparam logic [CNTW-1:0] ITER_MAX = CNTW'(MAX_ITER);

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] iter_q, iter_d;
    logic            abort_q, abort_d;

    // Round-robin pick. The search starts one past the last winner, so the
    // requester just served has the lowest priority.
    logic            win_found;
    logic [SELW-1:0] win_idx;
    logic [SELW-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = SELW'((int'(ptr_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        iter_d  = iter_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    sel_d   = win_idx;
                    gnt_d   = ONE_HOT0 << win_idx;
                    ptr_d   = win_idx;
                end
            end
            S_GRANT: begin
                iter_d  = '0;
                abort_d = 1'b0;
                state_d = S_LOADB;
            end
            S_LOADB: state_d = S_CHECK;
            S_CHECK: begin
                // B == 0 takes precedence, so an op of exactly MAX_ITER
                // iterations still finishes cleanly.
                if (eqz) begin
                    state_d = S_DONE;
                end else if (iter_q == ITER_MAX) begin
                    state_d = S_DONE;
                    abort_d = 1'b1;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                iter_d  = iter_q + CNTW'(1);
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                sel_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= PTR_RST;
            iter_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            iter_q  <= iter_d;
            abort_q <= abort_d;
        end
    end

    // Moore decode from the state register.
    assign ld_a     = (state_q == S_GRANT);
    assign ld_b     = (state_q == S_LOADB);
    assign clr      = (state_q == S_LOADB);
    assign ld_p     = (state_q == S_ACC);
    assign dec      = (state_q == S_ACC);
    assign done     = (state_q == S_DONE) ? (ONE_HOT0 << sel_q) : '0;
    assign err      = (state_q == S_DONE) && abort_q;
    assign busy     = (state_q != S_IDLE);
    assign sel      = sel_q;
    assign gnt      = gnt_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_mult_arbiter_ctrl.sv
// Bench for mult_arbiter_ctrl (NREQ=4, MAX_ITER=4). A small repeated-addition
// datapath driven by the DUT strobes provides eqz and the product. A timeline
// model, which knows only each op's cycle schedule, checks every output on
// every falling edge. Directed tasks pin literal cycle counts and products.
module tb_mult_arbiter_ctrl;

    localparam int NREQ = 4;
    localparam int MAXI = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       eqz;
    logic       ld_a, ld_b, clr, ld_p, dec, err, busy;
    logic [1:0] sel;
    logic [3:0] gnt, done;
    logic [7:0] iter_cnt;

    mult_arbiter_ctrl #(.NREQ(NREQ), .SELW(2), .CNTW(8), .MAX_ITER(MAXI)) dut (
        .clk(clk), .rst(rst), .req(req), .eqz(eqz),
        .ld_a(ld_a), .ld_b(ld_b), .clr(clr), .ld_p(ld_p), .dec(dec),
        .sel(sel), .gnt(gnt), .done(done), .err(err), .busy(busy),
        .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- datapath stand-in ----------------
    logic [7:0]  a_op [0:3];
    logic [7:0]  b_op [0:3];
    logic [7:0]  dp_a = '0;
    logic [7:0]  dp_b = '0;
    logic [15:0] dp_p = '0;
    logic        force0 = 1'b0;

    always @(posedge clk) begin
        if (ld_a) dp_a <= a_op[sel];
        if (ld_b) dp_b <= b_op[sel];
        if (clr)  dp_p <= '0;
        if (ld_p) dp_p <= dp_p + 16'(dp_a);
        if (dec)  dp_b <= dp_b - 8'd1;
    end
    assign eqz = force0 ? 1'b0 : (dp_b == 8'd0);

    // ---------------- scoring ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- timeline model ----------------
    // An op granted with B=n runs 2n+4 cycles (cycle 1 = GRANT). n is capped
    // at MAXI and flagged as an abort when B would never reach zero in time.
    bit  chk_en = 1'b0;
    bit  m_active = 1'b0;
    int  m_c = 0, m_len = 0, m_idx = 0, m_n = 0;
    int  m_ptr = NREQ - 1;
    int  m_last_iter = 0;
    bit  m_abort = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] e_gnt, e_done;
            logic       e_lda, e_ldb, e_acc, e_err, e_busy;
            int         e_sel, e_iter;
            bit         found;
            if (m_active) begin
                e_gnt  = 4'b0001 << m_idx;
                e_sel  = m_idx;
                e_busy = 1'b1;
                e_lda  = (m_c == 1);
                e_ldb  = (m_c == 2);
                e_acc  = (m_c >= 4) && (m_c < m_len) && (m_c % 2 == 0);
                e_done = (m_c == m_len) ? e_gnt : 4'b0000;
                e_err  = (m_c == m_len) && m_abort;
                e_iter = (m_c == 1) ? m_last_iter : ((m_c < 3) ? 0 : (m_c - 1) / 2 - 1);
            end else begin
                e_gnt = '0; e_sel = 0; e_busy = 1'b0; e_lda = 1'b0; e_ldb = 1'b0;
                e_acc = 1'b0; e_done = '0; e_err = 1'b0; e_iter = m_last_iter;
            end
            chk("m_sel",  32'(sel),      32'(e_sel));
            chk("m_gnt",  32'(gnt),      32'(e_gnt));
            chk("m_ld_a", 32'(ld_a),     32'(e_lda));
            chk("m_ld_b", 32'(ld_b),     32'(e_ldb));
            chk("m_clr",  32'(clr),      32'(e_ldb));
            chk("m_ld_p", 32'(ld_p),     32'(e_acc));
            chk("m_dec",  32'(dec),      32'(e_acc));
            chk("m_done", 32'(done),     32'(e_done));
            chk("m_err",  32'(err),      32'(e_err));
            chk("m_busy", 32'(busy),     32'(e_busy));
            chk("m_iter", 32'(iter_cnt), 32'(e_iter));
            // advance the model to the next cycle using the inputs the DUT
            // will sample at the coming rising edge
            if (rst) begin
                m_active = 1'b0; m_ptr = NREQ - 1; m_last_iter = 0;
            end else if (!m_active) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    int w;
                    w = (m_ptr + k) % NREQ;
                    if (!found && req[w]) begin
                        found = 1'b1; m_idx = w;
                    end
                end
                if (found) begin
                    m_active = 1'b1; m_c = 1; m_ptr = m_idx;
                    m_abort  = force0 || (int'(b_op[m_idx]) > MAXI);
                    m_n      = m_abort ? MAXI : int'(b_op[m_idx]);
                    m_len    = 2 * m_n + 4;
                end
            end else if (m_c == m_len) begin
                m_active = 1'b0; m_last_iter = m_n;
            end else begin
                m_c++;
            end
        end
    end

    // ---------------- directed operation ----------------
    task automatic run_op(input logic [3:0] r, input int exp_idx, input int exp_cyc,
                          input int exp_p, input int exp_iter, input bit exp_err,
                          input int exp_acc, input int drop_at);
        logic [3:0] oh;
        int done_cyc, acc, cyc;
        oh = 4'b0001 << exp_idx;
        done_cyc = 0; acc = 0; cyc = 0;
        req = r;
        while (done_cyc == 0 && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                chk("gnt_c1",  32'(gnt),  32'(oh));
                chk("ld_a_c1", 32'(ld_a), 1);
            end
            if (cyc == 2) chk("ldb_clr_c2", 32'({ld_b, clr}), 3);
            if (cyc == drop_at) req = r & ~oh;
            if (ld_p) acc++;
            if (done != 4'b0000) begin
                done_cyc = cyc;
                chk("done_vec", 32'(done),     32'(oh));
                chk("done_err", 32'(err),      32'(exp_err));
                chk("product",  32'(dp_p),     32'(exp_p));
                chk("iter_fin", 32'(iter_cnt), 32'(exp_iter));
                req = '0;
            end
        end
        chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        chk("acc_pulses", 32'(acc),      32'(exp_acc));
        req = '0;
        tick();
    endtask

    initial begin
        int gseq [0:4];
        int exp_seq [0:4];
        int ng, last_done, cyc;
        logic [3:0] prev_gnt;
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin a_op[i] = '0; b_op[i] = '0; end

        // reset
        tick();
        chk_en = 1'b1;
        chk("rst_outs", 32'({ld_a, ld_b, clr, ld_p, dec, sel, gnt, done, err, busy}), 0);
        chk("rst_iter", 32'(iter_cnt), 0);
        rst = 1'b0;
        tick();

        // single op A=5 B=3
        a_op[0] = 8'd5; b_op[0] = 8'd3;
        run_op(4'b0001, 0, 10, 15, 3, 1'b0, 3, 0);
        // zero operand
        a_op[1] = 8'd7; b_op[1] = 8'd0;
        run_op(4'b0010, 1, 4, 0, 0, 1'b0, 0, 0);
        // abort: eqz never seen
        force0 = 1'b1; a_op[2] = 8'd3; b_op[2] = 8'd9;
        run_op(4'b0100, 2, 12, 12, 4, 1'b1, 4, 0);
        force0 = 1'b0;
        // next request served normally
        a_op[3] = 8'd2; b_op[3] = 8'd2;
        run_op(4'b1000, 3, 8, 4, 2, 1'b0, 2, 0);
        // requester drop in cycle 3
        a_op[1] = 8'd6; b_op[1] = 8'd2;
        run_op(4'b0010, 1, 8, 12, 2, 1'b0, 2, 3);

        // reset during 2nd ACC of a B=5 op
        a_op[0] = 8'd1; b_op[0] = 8'd5;
        req = 4'b0001;
        repeat (6) tick();
        chk("acc2_before_rst", 32'(ld_p), 1);
        rst = 1'b1; req = '0;
        tick();
        chk("midrst_outs", 32'({ld_a, ld_b, clr, ld_p, dec, sel, gnt, done, err, busy}), 0);
        chk("midrst_iter", 32'(iter_cnt), 0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("no_done_after_rst", 32'(done), 0);
        end
        // pointer back at NREQ-1: requester 0 wins over 1
        b_op[0] = 8'd0; b_op[1] = 8'd0;
        run_op(4'b0011, 0, 4, 0, 0, 1'b0, 0, 0);
        a_op[2] = 8'd4; b_op[2] = 8'd2;
        run_op(4'b0100, 2, 8, 8, 2, 1'b0, 2, 0);

        // round robin with all requests held after reset
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin a_op[i] = 8'(i + 1); b_op[i] = 8'd1; end
        req = 4'b1111;
        ng = 0; last_done = 0; cyc = 0; prev_gnt = '0;
        while (cyc < 200 && !(ng == 5 && !busy)) begin
            tick();
            cyc++;
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                if (ng < 5) gseq[ng] = int'(sel);
                if (ng > 0) chk("rr_idle_gap", 32'(cyc - last_done), 2);
                else        chk("rr_first_grant", 32'(cyc), 1);
                ng++;
                if (ng == 5) req = '0;
            end
            if (done != 4'b0000) last_done = cyc;
            prev_gnt = gnt;
        end
        chk("rr_grant_count", 32'(ng), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) chk("rr_order", 32'(gseq[i]), 32'(exp_seq[i]));
        end
        repeat (2) tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
